// File: rtl/liquid_glitch_pkg.sv
// rtl/liquid_glitch_pkg.sv - shared types, constants and helpers for the glitch sequencer
//
// Contents:
//   state_t        sequencer FSM states
//   MODE_*         mode words driven onto the glitch datapath
//   SEQ_*          seq_mode input encodings
//   LFSR_TAPS      tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   lfsr_advance   one LFSR step
//   clamp_level    min(level, max_level)

package liquid_glitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MANUAL   = 3'd1,
        ST_SWEEP_UP = 3'd2,
        ST_SWEEP_DN = 3'd3,
        ST_RANDOM   = 3'd4
    } state_t;

    localparam logic [2:0] MODE_OFF = 3'b000;
    localparam logic [2:0] MODE_LV1 = 3'b001;
    localparam logic [2:0] MODE_LV2 = 3'b010;
    localparam logic [2:0] MODE_LV3 = 3'b011;

    localparam logic [1:0] SEQ_MANUAL     = 2'b00;
    localparam logic [1:0] SEQ_SWEEP      = 2'b01;
    localparam logic [1:0] SEQ_RANDOM     = 2'b10;
    localparam logic [1:0] SEQ_MANUAL_ALT = 2'b11;

    // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shift towards the MSB, feedback (XOR of the tapped bits) enters at bit 0.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [1:0] clamp_level(input logic [1:0] lvl, input logic [1:0] max_lvl);
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

endpackage

// File: rtl/glitch_lfsr.sv
// rtl/glitch_lfsr.sv - 16-bit Fibonacci LFSR for random-mode level selection
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, loads seed
//   step  in   advance one position this cycle
//   seed  in   [15:0] reset value (must be non-zero)
//   q     out  [15:0] current LFSR state

module glitch_lfsr
    import liquid_glitch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_advance(q);
        end
    end

endmodule

// File: rtl/liquid_glitch_seq.sv
// rtl/liquid_glitch_seq.sv - frame-synchronous glitch level sequencer (manual/sweep/random)
//
// Parameters:
//   HOLD_W        width of hold_frames and the frame-hold counter
//   LFSR_SEED     random-mode LFSR reset value (0 is replaced by 1)
// Ports:
//   clk           in   pixel clock
//   rst           in   synchronous active-high reset
//   vid_pVSync    in   vertical sync, active high
//   enable        in   sequencer on
//   seq_mode      in   [1:0] 00 manual, 01 sweep, 10 random, 11 manual
//   manual_level  in   [1:0] level for manual mode
//   max_level     in   [1:0] clamp for every selected level
//   hold_frames   in   [HOLD_W-1:0] frames per level minus one
//   mode_out      out  [2:0] registered mode word, {1'b0, level}
//   frame_tick    out  one-cycle pulse on every frame edge

module liquid_glitch_seq
    import liquid_glitch_pkg::*;
#(
    parameter int          HOLD_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_pVSync,
    input  logic              enable,
    input  logic [1:0]        seq_mode,
    input  logic [1:0]        manual_level,
    input  logic [1:0]        max_level,
    input  logic [HOLD_W-1:0] hold_frames,
    output logic [2:0]        mode_out,
    output logic              frame_tick
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic              vsync_q;
    logic              frame_edge;
    state_t            state, state_nx;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic [1:0]        lvl, lvl_nx;
    logic [2:0]        mode_nx;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_post;
    logic              lfsr_unused;
    logic              hold_done;
    logic              in_sweep;

    assign frame_edge = vid_pVSync & ~vsync_q;

    glitch_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (frame_edge),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    // Random levels use the value the LFSR takes at this same edge.
    assign lfsr_post   = lfsr_advance(lfsr_q);
    assign lfsr_unused = ^lfsr_post[15:2];

    assign hold_done = (cnt >= hold_frames);
    assign in_sweep  = (state == ST_SWEEP_UP) || (state == ST_SWEEP_DN);

    always_ff @(posedge clk) begin
        if (rst) begin
            // History starts high so a vsync already high at release is not an edge.
            vsync_q    <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            lvl        <= 2'd0;
            mode_out   <= MODE_OFF;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vid_pVSync;
            state      <= state_nx;
            cnt        <= cnt_nx;
            lvl        <= lvl_nx;
            mode_out   <= mode_nx;
            frame_tick <= frame_edge;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lvl_nx   = lvl;
        mode_nx  = mode_out;

        if (frame_edge) begin
            if (!enable) begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                lvl_nx   = 2'd0;
                mode_nx  = MODE_OFF;
            end else begin
                case (seq_mode)
                    SEQ_SWEEP: begin
                        if (!in_sweep) begin
                            state_nx = ST_SWEEP_UP;
                            cnt_nx   = '0;
                            lvl_nx   = 2'd0;
                        end else if (lvl > max_level) begin
                            // Clamp lowered ceiling and head back down from it.
                            state_nx = ST_SWEEP_DN;
                            cnt_nx   = '0;
                            lvl_nx   = max_level;
                        end else if (hold_done) begin
                            cnt_nx = '0;
                            if (max_level == 2'd0) begin
                                lvl_nx = 2'd0;
                            end else if (state == ST_SWEEP_UP) begin
                                if (lvl >= max_level) begin
                                    state_nx = ST_SWEEP_DN;
                                    lvl_nx   = lvl - 2'd1;
                                end else begin
                                    lvl_nx = lvl + 2'd1;
                                end
                            end else begin
                                if (lvl == 2'd0) begin
                                    state_nx = ST_SWEEP_UP;
                                    lvl_nx   = lvl + 2'd1;
                                end else begin
                                    lvl_nx = lvl - 2'd1;
                                end
                            end
                        end else begin
                            cnt_nx = cnt + HOLD_W'(1);
                        end
                        mode_nx = {1'b0, lvl_nx};
                    end

                    SEQ_RANDOM: begin
                        // Entry picks a fresh level immediately, then one per hold period.
                        if (state != ST_RANDOM) begin
                            state_nx = ST_RANDOM;
                            cnt_nx   = '0;
                            mode_nx  = {1'b0, clamp_level(lfsr_post[1:0], max_level)};
                        end else if (hold_done) begin
                            cnt_nx  = '0;
                            mode_nx = {1'b0, clamp_level(lfsr_post[1:0], max_level)};
                        end else begin
                            cnt_nx = cnt + HOLD_W'(1);
                        end
                    end

                    default: begin
                        state_nx = ST_MANUAL;
                        cnt_nx   = '0;
                        mode_nx  = {1'b0, clamp_level(manual_level, max_level)};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_liquid_glitch_seq.sv
// tb/tb_liquid_glitch_seq.sv - self-checking bench for liquid_glitch_seq

module tb_liquid_glitch_seq;

    localparam int SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       vid_pVSync;
    logic       enable;
    logic [1:0] seq_mode;
    logic [1:0] manual_level;
    logic [1:0] max_level;
    logic [7:0] hold_frames;
    logic [2:0] mode_out;
    logic       frame_tick;

    int          checks = 0;
    int          errors = 0;
    int unsigned m_lfsr;

    liquid_glitch_seq #(
        .HOLD_W    (8),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vid_pVSync   (vid_pVSync),
        .enable       (enable),
        .seq_mode     (seq_mode),
        .manual_level (manual_level),
        .max_level    (max_level),
        .hold_frames  (hold_frames),
        .mode_out     (mode_out),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11, shifting left.
    function automatic int unsigned model_lfsr_step(input int unsigned s);
        int unsigned fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 32'hFFFF;
    endfunction

    // Ping-pong level for frame f after sweep entry: triangle wave of period 2*mx.
    function automatic int sweep_level(input int f, input int hold, input int mx);
        int idx;
        int p;
        if (mx == 0) return 0;
        idx = f / (hold + 1);
        p   = idx % (2 * mx);
        return (p <= mx) ? p : 2 * mx - p;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic apply_reset(input logic vs_level);
        @(negedge clk);
        rst        = 1'b1;
        vid_pVSync = vs_level;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = SEED;
    endtask

    // One frame: vsync high 2 cycles, low 2 cycles. Returns outputs just after
    // the edge, and whether they stayed put (tick low) for the rest of the frame.
    task automatic do_frame(output logic [2:0] mo, output logic ft, output logic stable);
        @(negedge clk);
        vid_pVSync = 1'b1;
        @(posedge clk);
        #1;
        mo     = mode_out;
        ft     = frame_tick;
        stable = 1'b1;
        m_lfsr = model_lfsr_step(m_lfsr);
        @(negedge clk);
        @(posedge clk);
        #1;
        if (mode_out !== mo || frame_tick !== 1'b0) stable = 1'b0;
        @(negedge clk);
        vid_pVSync = 1'b0;
        @(posedge clk);
        #1;
        if (mode_out !== mo || frame_tick !== 1'b0) stable = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        if (mode_out !== mo || frame_tick !== 1'b0) stable = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] mo;
        logic       ft, st;
        enable = 1'b0; seq_mode = 2'b00; manual_level = 2'd0; max_level = 2'd3; hold_frames = 8'd0;
        apply_reset(1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (mode_out !== 3'b000 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: mode_out=%b frame_tick=%b expected 000/0", mode_out, frame_tick);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL vsync_high_at_release: frame_tick=%b expected 0", frame_tick);
            end
        end
        @(negedge clk);
        vid_pVSync = 1'b0;
        do_frame(mo, ft, st);
        checks++;
        if (ft !== 1'b1 || mo !== 3'b000 || st !== 1'b1) begin
            errors++;
            $display("FAIL idle_tick: tick=%b mode=%b stable=%b expected 1/000/1", ft, mo, st);
        end
    endtask

    task automatic test_sweep_basic();
        logic [2:0] mo, exp;
        logic       ft, st;
        apply_reset(1'b0);
        enable = 1'b1; seq_mode = 2'b01; max_level = 2'd3; hold_frames = 8'd0;
        for (int f = 0; f < 8; f++) begin
            do_frame(mo, ft, st);
            exp = 3'(sweep_level(f, 0, 3));
            checks++;
            if (mo !== exp || ft !== 1'b1 || st !== 1'b1) begin
                errors++;
                $display("FAIL sweep_basic f=%0d: mode=%b tick=%b stable=%b expected %b/1/1", f, mo, ft, st, exp);
            end
        end
    endtask

    task automatic test_sweep_hold();
        logic [2:0] mo, exp;
        logic       ft, st;
        apply_reset(1'b0);
        enable = 1'b1; seq_mode = 2'b01; max_level = 2'd1; hold_frames = 8'd2;
        for (int f = 0; f < 9; f++) begin
            do_frame(mo, ft, st);
            exp = 3'(sweep_level(f, 2, 1));
            checks++;
            if (mo !== exp || st !== 1'b1) begin
                errors++;
                $display("FAIL sweep_hold f=%0d: mode=%b stable=%b expected %b/1", f, mo, st, exp);
            end
        end
    endtask

    task automatic test_manual();
        logic [2:0] mo;
        logic       ft, st;
        apply_reset(1'b0);
        enable = 1'b1; seq_mode = 2'b00; manual_level = 2'd3; max_level = 2'd2; hold_frames = 8'd0;
        do_frame(mo, ft, st);
        checks++;
        if (mo !== 3'b010 || st !== 1'b1) begin
            errors++;
            $display("FAIL manual_clamp: mode=%b stable=%b expected 010/1", mo, st);
        end
        manual_level = 2'd1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mode_out !== 3'b010) begin
                errors++;
                $display("FAIL manual_midframe: mode=%b expected 010", mode_out);
            end
        end
        do_frame(mo, ft, st);
        checks++;
        if (mo !== 3'b001) begin
            errors++;
            $display("FAIL manual_next_edge: mode=%b expected 001", mo);
        end
        seq_mode = 2'b11; manual_level = 2'd3; max_level = 2'd3;
        do_frame(mo, ft, st);
        checks++;
        if (mo !== 3'b011) begin
            errors++;
            $display("FAIL manual_alt: mode=%b expected 011", mo);
        end
    endtask

    task automatic test_random();
        logic [2:0] mo, exp;
        logic       ft, st;
        apply_reset(1'b0);
        enable = 1'b1; seq_mode = 2'b10; max_level = 2'd3; hold_frames = 8'd0;
        for (int f = 0; f < 16; f++) begin
            do_frame(mo, ft, st);
            exp = 3'(min2(int'(m_lfsr & 3), 3));
            checks++;
            if (mo !== exp || st !== 1'b1) begin
                errors++;
                $display("FAIL random_max3 f=%0d: mode=%b stable=%b expected %b/1", f, mo, st, exp);
            end
        end
        max_level = 2'd1;
        for (int f = 0; f < 16; f++) begin
            do_frame(mo, ft, st);
            exp = 3'(min2(int'(m_lfsr & 3), 1));
            checks++;
            if (mo !== exp || mo > 3'b001) begin
                errors++;
                $display("FAIL random_max1 f=%0d: mode=%b expected %b", f, mo, exp);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [2:0] mo;
        logic       ft, st;
        // enable dropped mid-sweep
        apply_reset(1'b0);
        enable = 1'b1; seq_mode = 2'b01; max_level = 2'd3; hold_frames = 8'd0;
        for (int f = 0; f < 3; f++) do_frame(mo, ft, st);
        enable = 1'b0;
        do_frame(mo, ft, st);
        checks++;
        if (mo !== 3'b000 || ft !== 1'b1) begin
            errors++;
            $display("FAIL enable_off_midsweep: mode=%b tick=%b expected 000/1", mo, ft);
        end
        // max_level lowered below current sweep level
        enable = 1'b1;
        for (int f = 0; f < 4; f++) do_frame(mo, ft, st);
        checks++;
        if (mo !== 3'b011) begin
            errors++;
            $display("FAIL sweep_top: mode=%b expected 011", mo);
        end
        max_level = 2'd1;
        for (int f = 0; f < 3; f++) begin
            do_frame(mo, ft, st);
            checks++;
            if (mo !== ((f == 1) ? 3'b000 : 3'b001)) begin
                errors++;
                $display("FAIL max_drop f=%0d: mode=%b expected %b", f, mo, (f == 1) ? 3'b000 : 3'b001);
            end
        end
        // reset asserted on the edge cycle
        max_level = 2'd3;
        @(negedge clk);
        vid_pVSync = 1'b1;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mode_out !== 3'b000 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL rst_on_edge: mode=%b tick=%b expected 000/0", mode_out, frame_tick);
        end
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = SEED;
        @(posedge clk);
        #1;
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_high: tick=%b expected 0", frame_tick);
        end
        @(negedge clk);
        vid_pVSync = 1'b0;
        // reset mid-sweep resumes at level 0
        for (int f = 0; f < 2; f++) begin
            do_frame(mo, ft, st);
            checks++;
            if (mo !== 3'(f)) begin
                errors++;
                $display("FAIL resume_after_rst f=%0d: mode=%b expected %0d", f, mo, f);
            end
        end
    endtask

    task automatic test_randomized();
        logic [2:0] mo, exp;
        logic       ft, st;
        int         md, mx, ml, hold, n, cur;
        apply_reset(1'b0);
        for (int seg = 0; seg < 12; seg++) begin
            enable = 1'b0;
            do_frame(mo, ft, st);
            checks++;
            if (mo !== 3'b000) begin
                errors++;
                $display("FAIL rand_idle seg=%0d: mode=%b expected 000", seg, mo);
            end
            md   = int'($urandom_range(0, 3));
            mx   = int'($urandom_range(0, 3));
            ml   = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            n    = int'($urandom_range(3, 10));
            enable = 1'b1; seq_mode = 2'(md); max_level = 2'(mx);
            manual_level = 2'(ml); hold_frames = 8'(hold);
            cur = 0;
            for (int f = 0; f < n; f++) begin
                do_frame(mo, ft, st);
                if (md == 1) begin
                    exp = 3'(sweep_level(f, hold, mx));
                end else if (md == 2) begin
                    if (f % (hold + 1) == 0) cur = min2(int'(m_lfsr & 3), mx);
                    exp = 3'(cur);
                end else begin
                    exp = 3'(min2(ml, mx));
                end
                checks++;
                if (mo !== exp || ft !== 1'b1 || st !== 1'b1) begin
                    errors++;
                    $display("FAIL rand seg=%0d mode=%0d f=%0d: mode_out=%b tick=%b stable=%b expected %b/1/1",
                             seg, md, f, mo, ft, st, exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; vid_pVSync = 1'b0; enable = 1'b0; seq_mode = 2'b00;
        manual_level = 2'd0; max_level = 2'd0; hold_frames = 8'd0; m_lfsr = SEED;
        test_reset();
        test_sweep_basic();
        test_sweep_hold();
        test_manual();
        test_random();
        test_boundaries();
        test_randomized();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
